// File: rtl/lc3b_pkg.sv
// Shared LC-3b widths, requester indices and the writeback payload type.
package lc3b_pkg;

  localparam int unsigned REG_ADDR_W = 3;
  localparam int unsigned NREG       = 8;
  localparam int unsigned DATA_W     = 16;

  localparam int unsigned WB_ALU = 0;
  localparam int unsigned WB_MEM = 1;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter; last_grant advances only when a grant is issued.
module rr_arbiter2
  import lc3b_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt_c
);

  logic last_grant;

  // Grants are suppressed entirely while reset is held.
  always_comb begin
    gnt_c = 2'b00;
    if (!reset) begin
      if (req[WB_ALU] && req[WB_MEM]) begin
        if (last_grant) gnt_c[WB_ALU] = 1'b1;
        else            gnt_c[WB_MEM] = 1'b1;
      end else begin
        gnt_c = req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (|gnt_c) begin
      last_grant <= gnt_c[WB_MEM];
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file writeback scheduler: arbitration, write port register and
// pending-write scoreboard. Optional stall counter: REGFILE_WB_SCHED_STATS_EN.
module regfile_wb_scheduler
  import lc3b_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb0_valid,
  input  logic [REG_ADDR_W-1:0] wb0_addr,
  input  logic [DATA_W-1:0]     wb0_data,
  output logic                  wb0_ready,
  input  logic                  wb1_valid,
  input  logic [REG_ADDR_W-1:0] wb1_addr,
  input  logic [DATA_W-1:0]     wb1_data,
  output logic                  wb1_ready,
  output logic                  rf_write,
  output logic [REG_ADDR_W-1:0] rf_writeAdd,
  output logic [DATA_W-1:0]     rf_in,
  input  logic                  iss_valid,
  input  logic [REG_ADDR_W-1:0] iss_src1,
  input  logic                  iss_src1_en,
  input  logic [REG_ADDR_W-1:0] iss_src2,
  input  logic                  iss_src2_en,
  input  logic [REG_ADDR_W-1:0] iss_dest,
  input  logic                  iss_dest_en,
  output logic                  iss_stall,
  output logic [NREG-1:0]       pending,
  output logic                  sb_error,
  output logic [15:0]           stall_cnt
);

  logic [1:0]      gnt_c;
  logic            acc_c;
  wb_req_t         acc_req_c;
  logic            iss_fire_c;
  logic [NREG-1:0] pending_nxt_c;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({wb1_valid, wb0_valid}),
    .gnt_c (gnt_c)
  );

  assign wb0_ready = gnt_c[WB_ALU];
  assign wb1_ready = gnt_c[WB_MEM];
  assign acc_c     = |gnt_c;

  always_comb begin
    acc_req_c = '{addr: wb0_addr, data: wb0_data};
    if (gnt_c[WB_MEM]) acc_req_c = '{addr: wb1_addr, data: wb1_data};
  end

  // Source terms catch RAW; the dest term keeps one outstanding write per register.
  assign iss_stall = iss_valid &
                     ((iss_src1_en & pending[iss_src1]) |
                      (iss_src2_en & pending[iss_src2]) |
                      (iss_dest_en & pending[iss_dest]));
  assign iss_fire_c = iss_valid & ~iss_stall;

  // Clear applied before set so a same-edge set of the same register wins.
  always_comb begin
    pending_nxt_c = pending;
    if (acc_c) pending_nxt_c[acc_req_c.addr] = 1'b0;
    if (iss_fire_c && iss_dest_en) pending_nxt_c[iss_dest] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_write    <= 1'b0;
      rf_writeAdd <= '0;
      rf_in       <= '0;
      pending     <= '0;
      sb_error    <= 1'b0;
    end else begin
      rf_write <= acc_c;
      if (acc_c) begin
        rf_writeAdd <= acc_req_c.addr;
        rf_in       <= acc_req_c.data;
      end
      pending <= pending_nxt_c;
      if (acc_c && !pending[acc_req_c.addr]) sb_error <= 1'b1;
    end
  end

`ifdef REGFILE_WB_SCHED_STATS_EN
  // Saturating count of stalled decode cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 16'h0000;
    end else if (iss_stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed self-checking bench for regfile_wb_scheduler.
module tb_regfile_wb_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb0_valid, wb1_valid;
  logic [2:0]  wb0_addr, wb1_addr;
  logic [15:0] wb0_data, wb1_data;
  logic        wb0_ready, wb1_ready;
  logic        rf_write;
  logic [2:0]  rf_writeAdd;
  logic [15:0] rf_in;
  logic        iss_valid, iss_src1_en, iss_src2_en, iss_dest_en;
  logic [2:0]  iss_src1, iss_src2, iss_dest;
  logic        iss_stall;
  logic [7:0]  pending;
  logic        sb_error;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  regfile_wb_scheduler dut (
    .clk(clk), .reset(reset),
    .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
    .wb1_valid(wb1_valid), .wb1_addr(wb1_addr), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
    .rf_write(rf_write), .rf_writeAdd(rf_writeAdd), .rf_in(rf_in),
    .iss_valid(iss_valid), .iss_src1(iss_src1), .iss_src1_en(iss_src1_en),
    .iss_src2(iss_src2), .iss_src2_en(iss_src2_en),
    .iss_dest(iss_dest), .iss_dest_en(iss_dest_en),
    .iss_stall(iss_stall), .pending(pending), .sb_error(sb_error), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic issue(input logic [2:0] d);
    iss_valid = 1'b1; iss_dest = d; iss_dest_en = 1'b1;
    tick();
    iss_valid = 1'b0; iss_dest_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; wb0_valid = 1'b1; wb0_addr = 3'd3; wb0_data = 16'h1111;
    tick(); tick();
    checks++; if (wb0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", wb0_ready); end
    checks++; if (rf_write !== 1'b0) begin errors++; $display("FAIL reset_rf_write got %b exp 0", rf_write); end
    checks++; if (rf_writeAdd !== 3'd0) begin errors++; $display("FAIL reset_rf_addr got %0d exp 0", rf_writeAdd); end
    checks++; if (rf_in !== 16'h0000) begin errors++; $display("FAIL reset_rf_in got %h exp 0000", rf_in); end
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL reset_pending got %h exp 00", pending); end
    checks++; if (sb_error !== 1'b0) begin errors++; $display("FAIL reset_sb_error got %b exp 0", sb_error); end
    checks++; if (stall_cnt !== 16'h0000) begin errors++; $display("FAIL reset_stall_cnt got %h exp 0000", stall_cnt); end
    wb0_valid = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_wb();
    issue(3'd3);
    checks++; if (pending !== 8'h08) begin errors++; $display("FAIL single_pend_set got %h exp 08", pending); end
    wb0_valid = 1'b1; wb0_addr = 3'd3; wb0_data = 16'h1234;
    #1;
    checks++; if (wb0_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b exp 1", wb0_ready); end
    tick();
    wb0_valid = 1'b0;
    checks++; if (rf_write !== 1'b1) begin errors++; $display("FAIL single_rf_write got %b exp 1", rf_write); end
    checks++; if (rf_writeAdd !== 3'd3) begin errors++; $display("FAIL single_rf_addr got %0d exp 3", rf_writeAdd); end
    checks++; if (rf_in !== 16'h1234) begin errors++; $display("FAIL single_rf_in got %h exp 1234", rf_in); end
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL single_pend_clr got %h exp 00", pending); end
    checks++; if (sb_error !== 1'b0) begin errors++; $display("FAIL single_sb_error got %b exp 0", sb_error); end
    tick();
    checks++; if (rf_write !== 1'b0) begin errors++; $display("FAIL single_idle_write got %b exp 0", rf_write); end
    checks++; if (rf_writeAdd !== 3'd3) begin errors++; $display("FAIL single_addr_hold got %0d exp 3", rf_writeAdd); end
  endtask

  task automatic test_round_robin();
    logic [2:0] aa [4] = '{3'd1, 3'd3, 3'd3, 3'd5};
    logic [2:0] ma [4] = '{3'd2, 3'd2, 3'd4, 3'd4};
    logic       g  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  ea;
    logic [15:0] ed;
    do_reset();
    for (int i = 1; i <= 4; i++) issue(3'(i));
    checks++; if (pending !== 8'h1E) begin errors++; $display("FAIL rr_pend_set got %h exp 1e", pending); end
    for (int c = 0; c < 4; c++) begin
      wb0_valid = 1'b1; wb0_addr = aa[c]; wb0_data = 16'hA000 + 16'(aa[c]);
      wb1_valid = 1'b1; wb1_addr = ma[c]; wb1_data = 16'hB000 + 16'(ma[c]);
      ea = g[c] ? ma[c] : aa[c];
      ed = g[c] ? (16'hB000 + 16'(ma[c])) : (16'hA000 + 16'(aa[c]));
      #1;
      checks++; if ({wb1_ready, wb0_ready} !== (g[c] ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", c, {wb1_ready, wb0_ready}, g[c] ? 2'b10 : 2'b01); end
      tick();
      checks++; if ({rf_write, rf_writeAdd, rf_in} !== {1'b1, ea, ed}) begin errors++; $display("FAIL rr_write%0d got %b/%0d/%h exp 1/%0d/%h", c, rf_write, rf_writeAdd, rf_in, ea, ed); end
    end
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL rr_pend_clr got %h exp 00", pending); end
    checks++; if (sb_error !== 1'b0) begin errors++; $display("FAIL rr_sb_error got %b exp 0", sb_error); end
    tick();
    checks++; if (rf_write !== 1'b0) begin errors++; $display("FAIL rr_idle got %b exp 0", rf_write); end
  endtask

  task automatic test_raw();
    issue(3'd5);
    iss_valid = 1'b1; iss_src1 = 3'd5; iss_src1_en = 1'b1;
    #1;
    checks++; if (iss_stall !== 1'b1) begin errors++; $display("FAIL raw_stall0 got %b exp 1", iss_stall); end
    tick();
    checks++; if (iss_stall !== 1'b1) begin errors++; $display("FAIL raw_stall1 got %b exp 1", iss_stall); end
    wb0_valid = 1'b1; wb0_addr = 3'd5; wb0_data = 16'h5555;
    #1;
    checks++; if ({iss_stall, wb0_ready} !== 2'b11) begin errors++; $display("FAIL raw_accept_cycle got %b exp 11", {iss_stall, wb0_ready}); end
    tick();
    wb0_valid = 1'b0;
    #1;
    checks++; if (iss_stall !== 1'b0) begin errors++; $display("FAIL raw_release got %b exp 0", iss_stall); end
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL raw_pend got %h exp 00", pending); end
    tick();
    iss_valid = 1'b0; iss_src1_en = 1'b0;
  endtask

  task automatic test_waw();
    issue(3'd4);
    iss_valid = 1'b1; iss_dest = 3'd4; iss_dest_en = 1'b1;
    #1;
    checks++; if (iss_stall !== 1'b1) begin errors++; $display("FAIL waw_stall got %b exp 1", iss_stall); end
    tick();
    checks++; if ({iss_stall, pending} !== {1'b1, 8'h10}) begin errors++; $display("FAIL waw_hold1 got %b/%h exp 1/10", iss_stall, pending); end
    tick();
    checks++; if (pending !== 8'h10) begin errors++; $display("FAIL waw_hold2 got %h exp 10", pending); end
    iss_valid = 1'b0; iss_dest_en = 1'b0;
    wb0_valid = 1'b1; wb0_addr = 3'd4; wb0_data = 16'h4444;
    tick();
    wb0_valid = 1'b0;
    checks++; if ({pending, sb_error} !== {8'h00, 1'b0}) begin errors++; $display("FAIL waw_clean got %h/%b exp 00/0", pending, sb_error); end
  endtask

  task automatic test_sb_error();
    wb1_valid = 1'b1; wb1_addr = 3'd6; wb1_data = 16'hBEEF;
    #1;
    checks++; if (wb1_ready !== 1'b1) begin errors++; $display("FAIL sberr_ready got %b exp 1", wb1_ready); end
    tick();
    wb1_valid = 1'b0;
    checks++; if (sb_error !== 1'b1) begin errors++; $display("FAIL sberr_set got %b exp 1", sb_error); end
    checks++; if ({rf_write, rf_writeAdd, rf_in} !== {1'b1, 3'd6, 16'hBEEF}) begin errors++; $display("FAIL sberr_write got %b/%0d/%h exp 1/6/beef", rf_write, rf_writeAdd, rf_in); end
    tick(); tick();
    checks++; if (sb_error !== 1'b1) begin errors++; $display("FAIL sberr_sticky got %b exp 1", sb_error); end
    do_reset();
    checks++; if (sb_error !== 1'b0) begin errors++; $display("FAIL sberr_reset got %b exp 0", sb_error); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) issue(3'(i));
    checks++; if (pending !== 8'hFF) begin errors++; $display("FAIL rmid_pend_full got %h exp ff", pending); end
    wb0_valid = 1'b1; wb0_addr = 3'd0; wb0_data = 16'h7777;
    wb1_valid = 1'b1; wb1_addr = 3'd1; wb1_data = 16'h8888;
    reset = 1'b1;
    #1;
    checks++; if ({wb1_ready, wb0_ready} !== 2'b00) begin errors++; $display("FAIL rmid_ready got %b exp 00", {wb1_ready, wb0_ready}); end
    tick();
    checks++; if ({rf_write, pending, sb_error} !== {1'b0, 8'h00, 1'b0}) begin errors++; $display("FAIL rmid_state got %b/%h/%b exp 0/00/0", rf_write, pending, sb_error); end
    checks++; if (stall_cnt !== 16'h0000) begin errors++; $display("FAIL rmid_stall_cnt got %h exp 0000", stall_cnt); end
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    reset = 1'b0;
    tick();
    checks++; if (rf_write !== 1'b0) begin errors++; $display("FAIL rmid_after got %b exp 0", rf_write); end
  endtask

  task automatic test_stall_cnt();
    logic [15:0] exp_cnt;
`ifdef REGFILE_WB_SCHED_STATS_EN
    exp_cnt = 16'd3;
`else
    exp_cnt = 16'd0;
`endif
    do_reset();
    issue(3'd2);
    iss_valid = 1'b1; iss_dest = 3'd2; iss_dest_en = 1'b1;
    tick(); tick(); tick();
    iss_valid = 1'b0; iss_dest_en = 1'b0;
    #1;
    checks++; if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL stall_cnt got %0d exp %0d", stall_cnt, exp_cnt); end
    tick();
    checks++; if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL stall_cnt_hold got %0d exp %0d", stall_cnt, exp_cnt); end
    do_reset();
  endtask

  initial begin
    reset = 1'b1;
    wb0_valid = 1'b0; wb0_addr = '0; wb0_data = '0;
    wb1_valid = 1'b0; wb1_addr = '0; wb1_data = '0;
    iss_valid = 1'b0; iss_src1 = '0; iss_src1_en = 1'b0;
    iss_src2 = '0; iss_src2_en = 1'b0; iss_dest = '0; iss_dest_en = 1'b0;
    test_reset();
    test_single_wb();
    test_round_robin();
    test_raw();
    test_waw();
    test_sb_error();
    test_reset_mid();
    test_stall_cnt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
